// File: rtl/vc_arbiter.sv
// Two-VC to one-output arbiter with a registered forwarding stage.
// Define VC_ARB_WRR_EN for weighted round-robin; otherwise VC0 has strict priority.
module vc_arbiter #(
   parameter int DATA_W     = 6,
   parameter int VC0_WEIGHT = 4
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              vc0_empty,
   input  logic              vc1_empty,
   input  logic [DATA_W-1:0] vc0_data,
   input  logic [DATA_W-1:0] vc1_data,
   input  logic              pause_d0,
   input  logic              pause_d1,
   output logic              pop_vc0,
   output logic              pop_vc1,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [1:0]        grant
);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      SERVE_VC0 = 2'b01,
      SERVE_VC1 = 2'b10
   } state_t;

   state_t state;
   logic   eligible;
   logic   pick0;
   logic   pick1;

   assign eligible = !pause_d0 && !pause_d1;

`ifdef VC_ARB_WRR_EN
   localparam logic [2:0] WEIGHT = 3'(VC0_WEIGHT);

   logic [2:0] credit;
   logic       credit_ok;

   assign credit_ok = (credit < WEIGHT);

   always_comb begin
      pick0 = eligible && !vc0_empty && (vc1_empty || credit_ok);
      pick1 = eligible && !vc1_empty && !pick0;
   end

   // Credit counts consecutive VC0 pops, saturating at the weight.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         credit <= '0;
      end else if (pop_vc0) begin
         if (credit_ok)
            credit <= credit + 3'd1;
      end else if (pop_vc1) begin
         credit <= '0;
      end
   end
`else
   logic unused_weight;
   assign unused_weight = |VC0_WEIGHT;

   always_comb begin
      pick0 = eligible && !vc0_empty;
      pick1 = eligible && !vc1_empty && vc0_empty;
   end
`endif

   // Strobes are gated by reset so they drop without waiting for a clock.
   assign pop_vc0 = pick0 && reset_L;
   assign pop_vc1 = pick1 && reset_L;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state     <= IDLE;
         data_out  <= '0;
         valid_out <= 1'b0;
      end else if (pop_vc0) begin
         state     <= SERVE_VC0;
         data_out  <= vc0_data;
         valid_out <= 1'b1;
      end else if (pop_vc1) begin
         state     <= SERVE_VC1;
         data_out  <= vc1_data;
         valid_out <= 1'b1;
      end else begin
         state     <= IDLE;
         valid_out <= 1'b0;
      end
   end

   assign grant = state;

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter: vector table plus streaming,
// pause and reset sequences. Honours VC_ARB_WRR_EN like the design.
module tb_vc_arbiter;

   localparam int DW = 6;
`ifdef VC_ARB_WRR_EN
   localparam bit WRR = 1'b1;
`else
   localparam bit WRR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_L = 1'b0;
   logic          vc0_empty = 1'b1;
   logic          vc1_empty = 1'b1;
   logic [DW-1:0] vc0_data = '0;
   logic [DW-1:0] vc1_data = '0;
   logic          pause_d0 = 1'b0;
   logic          pause_d1 = 1'b0;
   logic          pop_vc0;
   logic          pop_vc1;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic [1:0]    grant;

   int tests = 0;
   int fails = 0;

   vc_arbiter #(.DATA_W(DW), .VC0_WEIGHT(4)) dut (
      .clk(clk), .reset_L(reset_L),
      .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
      .vc0_data(vc0_data), .vc1_data(vc1_data),
      .pause_d0(pause_d0), .pause_d1(pause_d1),
      .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
      .data_out(data_out), .valid_out(valid_out), .grant(grant)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Safety invariants, sampled mid-cycle
   always @(negedge clk) begin
      #2;
      if (reset_L) begin
         check("mutex", {31'd0, pop_vc0 & pop_vc1}, 32'd0);
         check("pop_empty0", {31'd0, pop_vc0 & vc0_empty}, 32'd0);
         check("pop_empty1", {31'd0, pop_vc1 & vc1_empty}, 32'd0);
      end
   end

   typedef struct {
      bit       e0, e1, p0, p1;
      bit [1:0] xw;
      bit [1:0] xs;
   } vec_t;

   function automatic vec_t mk(bit e0, bit e1, bit p0, bit p1,
                               bit [1:0] xw, bit [1:0] xs);
      vec_t v;
      v.e0 = e0; v.e1 = e1; v.p0 = p0; v.p1 = p1;
      v.xw = xw; v.xs = xs;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset_L   = 1'b0;
      vc0_empty = 1'b1;
      vc1_empty = 1'b1;
      pause_d0  = 1'b0;
      pause_d1  = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset_L = 1'b1;
   endtask

   function automatic bit exp_vc(int k);
      if (!WRR) return (k >= 10);
      if (k < 10) return (k % 5 == 4);
      if (k < 12) return 1'b0;
      return 1'b1;
   endfunction

   task automatic stream(input bit with_pause);
      logic [DW-1:0] q0[$];
      logic [DW-1:0] q1[$];
      int n_exp = 0;
      int n_dut = 0;
      int i0 = 0;
      int i1 = 0;
      bit paused;
      bit g0, g1, ev;
      logic [DW-1:0] ew;
      for (int k = 0; k < 10; k++) begin
         q0.push_back(DW'(k + 1));
         q1.push_back(DW'(8'h31 + k));
      end
      for (int cyc = 0; cyc < 60 && n_dut < 20; cyc++) begin
         @(negedge clk);
         paused    = with_pause && cyc >= 6 && cyc < 11;
         pause_d1  = paused;
         vc0_empty = (q0.size() == 0);
         vc1_empty = (q1.size() == 0);
         vc0_data  = vc0_empty ? '0 : q0[0];
         vc1_data  = vc1_empty ? '0 : q1[0];
         #1;
         g0 = pop_vc0;
         g1 = pop_vc1;
         ew = data_out;
         if (paused) begin
            check("pause_block", {30'd0, g1, g0}, 32'd0);
         end else begin
            ev = exp_vc(n_exp);
            check("pop_order", {30'd0, g1, g0}, ev ? 32'd2 : 32'd1);
            if (ev) begin
               ew = DW'(8'h31 + i1);
               i1++;
            end else begin
               ew = DW'(i0 + 1);
               i0++;
            end
            n_exp++;
         end
         @(posedge clk);
         if (g0) void'(q0.pop_front());
         if (g1) void'(q1.pop_front());
         if (g0 || g1) n_dut++;
         #1;
         check("stream_valid", {31'd0, valid_out}, {31'd0, !paused});
         if (!paused)
            check("stream_data", {26'd0, data_out}, {26'd0, ew});
      end
      check("stream_count", n_dut, 20);
      pause_d1 = 1'b0;
   endtask

   vec_t tbl[23];
   logic [DW-1:0] held;
   bit [1:0] xp;

   initial begin
      tbl[0]  = mk(1, 1, 0, 0, 2'b00, 2'b00);
      tbl[1]  = mk(0, 1, 1, 0, 2'b00, 2'b00);
      tbl[2]  = mk(0, 0, 0, 1, 2'b00, 2'b00);
      tbl[3]  = mk(0, 1, 0, 0, 2'b01, 2'b01);
      tbl[4]  = mk(0, 0, 0, 0, 2'b01, 2'b01);
      tbl[5]  = mk(0, 0, 0, 0, 2'b01, 2'b01);
      tbl[6]  = mk(0, 0, 0, 0, 2'b01, 2'b01);
      tbl[7]  = mk(0, 0, 0, 0, 2'b10, 2'b01);
      tbl[8]  = mk(1, 0, 0, 0, 2'b10, 2'b10);
      tbl[9]  = mk(0, 0, 0, 0, 2'b01, 2'b01);
      tbl[10] = mk(0, 0, 0, 1, 2'b00, 2'b00);
      tbl[11] = mk(0, 1, 0, 0, 2'b01, 2'b01);
      tbl[12] = mk(0, 1, 0, 0, 2'b01, 2'b01);
      tbl[13] = mk(0, 1, 0, 0, 2'b01, 2'b01);
      tbl[14] = mk(0, 1, 0, 0, 2'b01, 2'b01);
      tbl[15] = mk(0, 0, 0, 0, 2'b10, 2'b01);
      tbl[16] = mk(0, 0, 0, 0, 2'b01, 2'b01);
      tbl[17] = mk(1, 1, 0, 0, 2'b00, 2'b00);
      tbl[18] = mk(1, 0, 0, 0, 2'b10, 2'b10);
      tbl[19] = mk(1, 0, 0, 0, 2'b10, 2'b10);
      tbl[20] = mk(1, 0, 0, 0, 2'b10, 2'b10);
      tbl[21] = mk(1, 1, 0, 0, 2'b00, 2'b00);
      tbl[22] = mk(1, 1, 1, 1, 2'b00, 2'b00);

      // Outputs held at zero during reset even with data offered
      #12;
      vc0_empty = 1'b0;
      vc1_empty = 1'b0;
      vc0_data  = 6'h2a;
      vc1_data  = 6'h15;
      @(posedge clk);
      #1;
      check("rst_pop0", {31'd0, pop_vc0}, 32'd0);
      check("rst_pop1", {31'd0, pop_vc1}, 32'd0);
      check("rst_valid", {31'd0, valid_out}, 32'd0);
      check("rst_data", {26'd0, data_out}, 32'd0);
      check("rst_grant", {30'd0, grant}, 32'd0);

      // Vector table, run in sequence from a fresh reset
      do_reset();
      held = '0;
      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         vc0_empty = tbl[i].e0;
         vc1_empty = tbl[i].e1;
         pause_d0  = tbl[i].p0;
         pause_d1  = tbl[i].p1;
         vc0_data  = DW'(i);
         vc1_data  = DW'(32 + i);
         xp = WRR ? tbl[i].xw : tbl[i].xs;
         #1;
         check($sformatf("vec%0d_pop", i), {30'd0, pop_vc1, pop_vc0}, {30'd0, xp});
         if (xp == 2'b01) held = DW'(i);
         if (xp == 2'b10) held = DW'(32 + i);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_valid", i), {31'd0, valid_out}, {31'd0, |xp});
         check($sformatf("vec%0d_data", i), {26'd0, data_out}, {26'd0, held});
         check($sformatf("vec%0d_grant", i), {30'd0, grant}, {30'd0, xp});
      end

      do_reset();
      stream(1'b0);
      do_reset();
      stream(1'b1);

      // Reset mid-stream: immediate clear, credit restarts at zero
      do_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         vc0_empty = 1'b0;
         vc1_empty = 1'b0;
         vc0_data  = 6'h15;
         vc1_data  = 6'h2a;
      end
      @(posedge clk);
      @(negedge clk);
      #2 reset_L = 1'b0;
      #1;
      check("mid_rst_pop", {30'd0, pop_vc1, pop_vc0}, 32'd0);
      check("mid_rst_valid", {31'd0, valid_out}, 32'd0);
      check("mid_rst_data", {26'd0, data_out}, 32'd0);
      check("mid_rst_grant", {30'd0, grant}, 32'd0);
      repeat (2) @(posedge clk);
      #2 reset_L = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         check($sformatf("post_rst%0d", c), {30'd0, pop_vc1, pop_vc0},
               (WRR && c == 4) ? 32'd2 : 32'd1);
         @(posedge clk);
      end

      do_reset();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 Parameter DATA_W, default 6, width of VC FIFO words and data_out.
REQ-002 Parameter VC0_WEIGHT, default 4, legal range 1..7; VC0 pops allowed before VC1 is forced in when both are non-empty.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 vc0_empty  input  1  VC0 FIFO empty flag.
REQ-006 vc1_empty  input  1  VC1 FIFO empty flag.
REQ-007 vc0_data  input  DATA_W  VC0 FIFO head word, show-ahead (valid while vc0_empty=0).
REQ-008 vc1_data  input  DATA_W  VC1 FIFO head word, show-ahead.
REQ-009 pause_d0  input  1  destination FIFO D0 almost-full.
REQ-010 pause_d1  input  1  destination FIFO D1 almost-full.
REQ-011 pop_vc0  output  1  combinational pop strobe to VC0 FIFO.
REQ-012 pop_vc1  output  1  combinational pop strobe to VC1 FIFO.
REQ-013 data_out  output  DATA_W  registered word forwarded toward D0/D1 demux.
REQ-014 valid_out  output  1  registered qualifier for data_out.
REQ-015 grant  output  2  registered FSM state: 00 IDLE, 01 SERVE_VC0, 10 SERVE_VC1; 11 never driven.

Function
REQ-016 The block SHALL define eligible = !pause_d0 && !pause_d1; no pop occurs when eligible=0.
REQ-017 pop_vc0 and pop_vc1 SHALL never be asserted in the same cycle.
REQ-018 The block SHALL pop only a non-empty FIFO; popping an empty FIFO is forbidden.
REQ-019 The block SHALL hold a 3-bit credit counter of consecutive VC0 pops.
REQ-020 Decision, when eligible and only VC0 is non-empty: pop_vc0=1; credit becomes min(credit+1, VC0_WEIGHT).
REQ-021 Decision, when eligible and only VC1 is non-empty: pop_vc1=1; credit becomes 0.
REQ-022 Decision, when eligible and both are non-empty: pop_vc0=1 and credit+1 if credit<VC0_WEIGHT, else pop_vc1=1 and credit becomes 0.
REQ-023 Decision, when not eligible or both are empty: no pop; credit is held.
REQ-024 The FSM next state SHALL be SERVE_VC0 on a VC0 pop, SERVE_VC1 on a VC1 pop, and IDLE otherwise; any state may go to any state.
REQ-025 On the edge ending a pop cycle, data_out SHALL load the popped head word and valid_out SHALL be 1 (latency 1 cycle); in a cycle with no pop, valid_out SHALL be 0 and data_out SHALL hold.
REQ-026 A pause that asserts in a given cycle SHALL block that same cycle's pop (combinational path).
REQ-027 Back-to-back pops SHALL be supported: one word per cycle at full throughput.

Reset
REQ-028 While reset_L=0: pop_vc0=0, pop_vc1=0, data_out=0, valid_out=0, grant=00, credit=0, independent of clk.
REQ-029 Reset asserted mid-transfer SHALL discard the in-flight registered word; the first pop after release SHALL occur no earlier than the first rising edge with reset_L=1.

Configuration
REQ-030 Macro VC_ARB_WRR_EN defined: weighted round-robin per REQ-019..REQ-022.
REQ-031 Macro VC_ARB_WRR_EN undefined: strict priority, with VC1 popped only when VC0 is empty; credit logic is absent and VC0_WEIGHT is ignored; all other requirements hold.

Verification (VC0_WEIGHT=4, VC_ARB_WRR_EN defined unless noted)
REQ-032 Both FIFOs are loaded with 10 words and there is no pause -> pop order is VC0 x4, VC1, VC0 x4, VC1, ...; valid_out is continuous starting one cycle after the first pop.
REQ-033 Only VC1 holds 3 words -> pop_vc1 is asserted for 3 consecutive cycles, grant=10, then grant=00 and valid_out=0.
REQ-034 pause_d1 is asserted for 5 cycles during streaming -> no pop in those cycles, credit is held, and after release the sequence resumes where it stopped.
REQ-035 reset_L is pulsed low for 2 cycles mid-stream, between edges -> outputs go to 0 immediately, and credit restarts at 0 after release.
REQ-036 VC_ARB_WRR_EN undefined, both FIFOs hold 6 words -> six VC0 pops, then six VC1 pops.
REQ-037 All tests: the bench checks that pop_vc0 and pop_vc1 are never both 1 and that no pop is issued to an empty FIFO.
